// File: rtl/stage_phv_fifo.sv
// PHV ingress buffer upstream of an RMT stage: registered output, early backpressure, drop counter.
// Optional peak-occupancy watermark enabled by STAGE_PHV_FIFO_WMARK_EN.
module stage_phv_fifo #(
    parameter int PHV_LEN    = 48*8+32*8+16*8+5*20+256,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int AFULL_TH   = 6
) (
    input  logic                  axis_clk,
    input  logic                  aresetn,
    input  logic [PHV_LEN-1:0]    phv_in,
    input  logic                  phv_in_valid,
    output logic                  fifo_ready,
    output logic [PHV_LEN-1:0]    phv_out,
    output logic                  phv_out_valid,
    input  logic                  stg_ready,
    output logic [ADDR_WIDTH:0]   occupancy,
`ifdef STAGE_PHV_FIFO_WMARK_EN
    input  logic                  wmark_clr,
    output logic [ADDR_WIDTH:0]   occ_max,
`endif
    output logic [15:0]           drop_cnt
);

    localparam logic [ADDR_WIDTH:0] FULL_CNT  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_CNT = (ADDR_WIDTH+1)'(AFULL_TH);

    logic [PHV_LEN-1:0]    mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic [ADDR_WIDTH:0]   next_count;
    logic                  full;
    logic                  empty;
    logic                  rd;
    logic                  wr;
    logic                  drop;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign rd    = stg_ready && !empty;
    // A full FIFO still takes a write when the same cycle frees a slot.
    assign wr    = phv_in_valid && (!full || rd);
    assign drop  = phv_in_valid && full && !rd;

    assign fifo_ready = (count < AFULL_CNT);
    assign occupancy  = count;

    always_comb begin
        next_count = count;
        unique case ({wr, rd})
            2'b10:   next_count = count + 1'b1;
            2'b01:   next_count = count - 1'b1;
            default: next_count = count;
        endcase
    end

    always_ff @(posedge axis_clk) begin
        if (wr) mem[wr_ptr] <= phv_in;
    end

    always_ff @(posedge axis_clk) begin
        if (!aresetn) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            phv_out       <= '0;
            phv_out_valid <= 1'b0;
            drop_cnt      <= '0;
        end else begin
            count         <= next_count;
            phv_out_valid <= rd;
            if (wr) wr_ptr <= wr_ptr + 1'b1;
            if (rd) begin
                rd_ptr  <= rd_ptr + 1'b1;
                phv_out <= mem[rd_ptr];
            end
            if (drop && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;
        end
    end

`ifdef STAGE_PHV_FIFO_WMARK_EN
    always_ff @(posedge axis_clk) begin
        if (!aresetn)
            occ_max <= '0;
        else if (wmark_clr)
            occ_max <= next_count;
        else if (next_count > occ_max)
            occ_max <= next_count;
    end
`endif

endmodule
